// File: rtl/ym_stereo_accumulator.sv
// Frame-level stereo mixer: sums panned, time-multiplexed channel slots and emits saturated PCM per frame.
// Optional one-pole output low-pass filter is enabled by defining YM_STEREO_ACC_LPF_EN.
module ym_stereo_accumulator #(
    parameter int unsigned NUM_CH     = 6,
    parameter int unsigned IN_W       = 9,
    parameter int unsigned OUT_W      = 16,
    parameter int unsigned GAIN_SHIFT = 5,
    parameter int unsigned LPF_SHIFT  = 3
) (
    input  logic                      MCLK,
    input  logic                      reset,
    input  logic                      slot_en,
    input  logic [$clog2(NUM_CH)-1:0] slot_ch,
    input  logic [IN_W-1:0]           slot_data,
    input  logic [1:0]                slot_pan,
    input  logic                      slot_active,
    output logic [OUT_W-1:0]          out_l,
    output logic [OUT_W-1:0]          out_r,
    output logic                      out_valid,
    output logic [1:0]                clip,
    output logic                      dup_err
);

    localparam int unsigned CH_W = $clog2(NUM_CH);
    localparam int unsigned A_W  = IN_W + CH_W + 1;
    localparam int unsigned Y_W  = (A_W + GAIN_SHIFT > OUT_W) ? (A_W + GAIN_SHIFT) : OUT_W;
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [CH_W:0]   NUM_CH_X = (CH_W + 1)'(NUM_CH);

    logic signed [A_W-1:0] acc_l, acc_r;
    logic [NUM_CH-1:0]     seen;

    logic signed [IN_W-1:0] s;
    logic signed [A_W-1:0]  con_l, con_r, sum_l, sum_r;
    logic                   in_range, seen_hit, accept, dup, close;
    logic [NUM_CH-1:0]      seen_set;
    logic [OUT_W:0]         sat_l, sat_r;

    // Gain-shift then clamp to OUT_W; MSB of the result is the clip flag.
    function automatic logic [OUT_W:0] sat(input logic signed [A_W-1:0] v);
        logic signed [Y_W-1:0] y;
        logic [Y_W-OUT_W:0]    hi;
        y  = Y_W'(v);
        y  = y <<< GAIN_SHIFT;
        hi = y[Y_W-1:OUT_W-1];
        if ((&hi) || (~|hi))
            return {1'b0, y[OUT_W-1:0]};
        else if (y[Y_W-1])
            return {1'b1, 1'b1, (OUT_W-1)'(0)};
        else
            return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
    endfunction

    // Slot decode: signed conversion, duplicate/range check, panned contribution.
    always_comb begin
        s        = signed'({~slot_data[IN_W-1], slot_data[IN_W-2:0]});
        in_range = ({1'b0, slot_ch} < NUM_CH_X);
        seen_hit = 1'b0;
        seen_set = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (slot_ch == CH_W'(i)) begin
                seen_hit    = seen[i];
                seen_set[i] = 1'b1;
            end
        end
        accept = slot_en & in_range & ~seen_hit;
        dup    = slot_en & (~in_range | seen_hit);
        close  = slot_en & (slot_ch == LAST_CH);
        con_l  = (accept & slot_active & slot_pan[1]) ? A_W'(s) : '0;
        con_r  = (accept & slot_active & slot_pan[0]) ? A_W'(s) : '0;
        sum_l  = acc_l + con_l;
        sum_r  = acc_r + con_r;
        sat_l  = sat(sum_l);
        sat_r  = sat(sum_r);
    end

    // Frame accumulators, seen mask and sticky index error.
    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            acc_l   <= '0;
            acc_r   <= '0;
            seen    <= '0;
            dup_err <= 1'b0;
        end else begin
            if (dup)
                dup_err <= 1'b1;
            if (close) begin
                acc_l <= '0;
                acc_r <= '0;
                seen  <= '0;
            end else if (accept) begin
                acc_l <= sum_l;
                acc_r <= sum_r;
                seen  <= seen | seen_set;
            end
        end
    end

`ifdef YM_STEREO_ACC_LPF_EN
    localparam int unsigned F_W = OUT_W + LPF_SHIFT;

    logic [OUT_W-1:0]      y_l_q, y_r_q;
    logic [1:0]            clip_q;
    logic                  vld_q;
    logic signed [F_W-1:0] f_l, f_r;

    // f += ((y << LPF_SHIFT) - f) >>> LPF_SHIFT, all in the extended fixed-point domain.
    function automatic logic signed [F_W-1:0] lpf_step(input logic signed [F_W-1:0] f,
                                                       input logic [OUT_W-1:0] y);
        logic signed [F_W:0] yx;
        logic signed [F_W:0] d;
        yx = (F_W + 1)'(signed'(y));
        yx = yx <<< LPF_SHIFT;
        d  = (yx - (F_W + 1)'(f)) >>> LPF_SHIFT;
        return f + F_W'(d);
    endfunction

    // Saturated sample stage followed by the filter stage.
    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            y_l_q     <= '0;
            y_r_q     <= '0;
            clip_q    <= '0;
            vld_q     <= 1'b0;
            f_l       <= '0;
            f_r       <= '0;
            clip      <= '0;
            out_valid <= 1'b0;
        end else begin
            vld_q     <= close;
            out_valid <= vld_q;
            if (close) begin
                y_l_q  <= sat_l[OUT_W-1:0];
                y_r_q  <= sat_r[OUT_W-1:0];
                clip_q <= {sat_l[OUT_W], sat_r[OUT_W]};
            end
            if (vld_q) begin
                f_l  <= lpf_step(f_l, y_l_q);
                f_r  <= lpf_step(f_r, y_r_q);
                clip <= clip_q;
            end
        end
    end

    assign out_l = f_l[F_W-1:LPF_SHIFT];
    assign out_r = f_r[F_W-1:LPF_SHIFT];
`else
    // Output registers load on the edge that samples the closing slot.
    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            out_l     <= '0;
            out_r     <= '0;
            clip      <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= close;
            if (close) begin
                out_l <= sat_l[OUT_W-1:0];
                out_r <= sat_r[OUT_W-1:0];
                clip  <= {sat_l[OUT_W], sat_r[OUT_W]};
            end
        end
    end
`endif

endmodule

// File: tb/tb_ym_stereo_accumulator.sv
// Directed bench for ym_stereo_accumulator in its default build (6 channels, 9-bit in, 16-bit out).
module tb_ym_stereo_accumulator;

    localparam int NV = 12;

    logic        MCLK = 1'b0;
    logic        reset;
    logic        slot_en;
    logic [2:0]  slot_ch;
    logic [8:0]  slot_data;
    logic [1:0]  slot_pan;
    logic        slot_active;
    logic [15:0] out_l, out_r;
    logic        out_valid;
    logic [1:0]  clip;
    logic        dup_err;

    ym_stereo_accumulator dut (
        .MCLK        (MCLK),
        .reset       (reset),
        .slot_en     (slot_en),
        .slot_ch     (slot_ch),
        .slot_data   (slot_data),
        .slot_pan    (slot_pan),
        .slot_active (slot_active),
        .out_l       (out_l),
        .out_r       (out_r),
        .out_valid   (out_valid),
        .clip        (clip),
        .dup_err     (dup_err)
    );

    always #5 MCLK = ~MCLK;

    typedef struct {
        logic [5:0][8:0] data;
        logic [5:0][1:0] pan;
        logic [5:0]      act;
        logic [15:0]     el;
        logic [15:0]     er;
        logic [1:0]      ec;
    } vec_t;

    vec_t v [NV];
    int   n_cmp = 0;
    int   n_err = 0;
    int   vcnt  = 0;
    int   vbase;

    always @(negedge MCLK) if (out_valid === 1'b1) vcnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int ch, input logic [8:0] d, input logic [1:0] p, input logic a);
        @(negedge MCLK);
        slot_en     = 1'b1;
        slot_ch     = 3'(ch);
        slot_data   = d;
        slot_pan    = p;
        slot_active = a;
    endtask

    task automatic idle();
        @(negedge MCLK);
        slot_en     = 1'b0;
        slot_ch     = '0;
        slot_data   = '0;
        slot_pan    = '0;
        slot_active = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [15:0] el, input logic [15:0] er,
                           input logic [1:0] ec);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".out_l"}, 32'(out_l), 32'(el));
        chk({tag, ".out_r"}, 32'(out_r), 32'(er));
        chk({tag, ".clip"},  32'(clip),  32'(ec));
    endtask

    task automatic set_row(input int k, input logic [8:0] d, input logic [1:0] p,
                           input logic [15:0] el, input logic [15:0] er, input logic [1:0] ec);
        for (int c = 0; c < 6; c++) begin
            v[k].data[c] = d;
            v[k].pan[c]  = p;
            v[k].act[c]  = 1'b1;
        end
        v[k].el = el;
        v[k].er = er;
        v[k].ec = ec;
    endtask

    initial begin
        // Frame vectors: expected value = clamp(sum(s) * 32) per side.
        set_row(0, 9'h100, 2'd3, 16'h0000, 16'h0000, 2'b00);
        set_row(1, 9'h100, 2'd3, 16'h0000, 16'h1000, 2'b00);
        v[1].data[0] = 9'h180; v[1].pan[0] = 2'd1;
        set_row(2, 9'h100, 2'd3, 16'h0000, 16'h0000, 2'b00);
        v[2].data[0] = 9'h180; v[2].pan[0] = 2'd1; v[2].act[0] = 1'b0;
        set_row(3, 9'h1FF, 2'd3, 16'h7FFF, 16'h7FFF, 2'b11);
        set_row(4, 9'h000, 2'd3, 16'h8000, 16'h8000, 2'b11);
        set_row(5, 9'h100, 2'd3, 16'h1FE0, 16'hE000, 2'b00);
        v[5].data[0] = 9'h1FF; v[5].pan[0] = 2'd2;
        v[5].data[1] = 9'h000; v[5].pan[1] = 2'd1;
        set_row(6, 9'h1FF, 2'd2, 16'h7FFF, 16'h0000, 2'b10);
        set_row(7, 9'h1FF, 2'd3, 16'h7FE0, 16'h7FE0, 2'b00);
        v[7].data[4] = 9'h103; v[7].data[5] = 9'h100;
        set_row(8, 9'h1FF, 2'd3, 16'h7FFF, 16'h7FFF, 2'b11);
        v[8].data[4] = 9'h104; v[8].data[5] = 9'h100;
        set_row(9, 9'h000, 2'd3, 16'h8000, 16'h8000, 2'b00);
        v[9].data[4] = 9'h100; v[9].data[5] = 9'h100;
        set_row(10, 9'h000, 2'd3, 16'h8000, 16'h8000, 2'b11);
        v[10].data[4] = 9'h0FF; v[10].data[5] = 9'h100;
        set_row(11, 9'h1FF, 2'd0, 16'h0000, 16'h0000, 2'b00);

        reset = 1'b1;
        slot_en = 1'b0; slot_ch = '0; slot_data = '0; slot_pan = '0; slot_active = 1'b0;
        @(negedge MCLK);
        @(negedge MCLK);
        chk("rst.out_l", 32'(out_l), 32'd0);
        chk("rst.out_r", 32'(out_r), 32'd0);
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.clip", 32'(clip), 32'd0);
        chk("rst.dup_err", 32'(dup_err), 32'd0);
        reset = 1'b0;

        for (int k = 0; k < NV; k++) begin
            for (int c = 0; c < 6; c++) begin
                drive(c, v[k].data[c], v[k].pan[c], v[k].act[c]);
                if (c == 5) chk($sformatf("vec%0d.prevalid", k), 32'(out_valid), 32'd0);
            end
            idle();
            chk_out($sformatf("vec%0d", k), v[k].el, v[k].er, v[k].ec);
            idle();
            chk($sformatf("vec%0d.drop", k), 32'(out_valid), 32'd0);
            chk($sformatf("vec%0d.hold", k), 32'(out_l), 32'(v[k].el));
        end
        chk("table.dup_err", 32'(dup_err), 32'd0);

        // Duplicate ch2 counted once; missing channels are zero; error is sticky.
        drive(2, 9'h140, 2'd3, 1'b1);
        drive(2, 9'h140, 2'd3, 1'b1);
        drive(5, 9'h100, 2'd3, 1'b1);
        idle();
        chk_out("dup", 16'h0800, 16'h0800, 2'b00);
        chk("dup.err", 32'(dup_err), 32'd1);
        for (int c = 0; c < 6; c++) drive(c, 9'h100, 2'd3, 1'b1);
        idle();
        chk_out("dup.next", 16'h0000, 16'h0000, 2'b00);
        chk("dup.sticky", 32'(dup_err), 32'd1);

        // Reset clears the sticky error; out-of-range index then sets it and is discarded.
        @(negedge MCLK); reset = 1'b1;
        @(negedge MCLK); reset = 1'b0;
        chk("rst2.dup_err", 32'(dup_err), 32'd0);
        drive(6, 9'h1FF, 2'd3, 1'b1);
        drive(7, 9'h1FF, 2'd3, 1'b1);
        drive(5, 9'h100, 2'd3, 1'b1);
        idle();
        chk_out("range", 16'h0000, 16'h0000, 2'b00);
        chk("range.err", 32'(dup_err), 32'd1);

        // Reset mid-frame discards the partial sum.
        for (int c = 0; c < 4; c++) drive(c, 9'h1FF, 2'd3, 1'b1);
        @(negedge MCLK); reset = 1'b1; slot_en = 1'b0;
        @(negedge MCLK); reset = 1'b0;
        chk("midrst.dup_err", 32'(dup_err), 32'd0);
        chk("midrst.valid", 32'(out_valid), 32'd0);
        drive(5, 9'h110, 2'd3, 1'b1);
        idle();
        chk_out("midrst", 16'h0200, 16'h0200, 2'b00);

        // Idle cycles inside a frame hold accumulated state.
        drive(0, 9'h120, 2'd3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk($sformatf("gap%0d.valid", i), 32'(out_valid), 32'd0);
            chk($sformatf("gap%0d.hold", i), 32'(out_r), 32'h0200);
        end
        drive(5, 9'h100, 2'd3, 1'b1);
        idle();
        chk_out("gap", 16'h0400, 16'h0400, 2'b00);
        chk("gap.dup_err", 32'(dup_err), 32'd0);

        // Back-to-back frames with no idle cycle: one pulse and a fresh sum per frame.
        idle();
        vbase = vcnt;
        for (int f = 0; f < 3; f++) begin
            for (int c = 0; c < 6; c++) begin
                @(negedge MCLK);
                if (c == 0 && f > 0) begin
                    chk($sformatf("b2b%0d.valid", f - 1), 32'(out_valid), 32'd1);
                    chk($sformatf("b2b%0d.out_l", f - 1), 32'(out_l), 32'(16'(256 * f)));
                end
                slot_en     = 1'b1;
                slot_ch     = 3'(c);
                slot_data   = (c == 0) ? 9'(9'h100 + 8 * (f + 1)) : 9'h100;
                slot_pan    = 2'd3;
                slot_active = 1'b1;
            end
        end
        idle();
        chk_out("b2b2", 16'h0300, 16'h0300, 2'b00);
        idle();
        chk("b2b.pulses", 32'(vcnt - vbase), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ym_stereo_accumulator.md
# ym_stereo_accumulator

Frame-level stereo mixer placed after the channel output stage. It receives one time-multiplexed channel sample per slot, in offset binary, together with that slot's pan bits and output-enable. Each enabled channel is summed into left and right accumulators, and at the end of every frame the block emits one saturated, gain-scaled signed stereo PCM sample with a single-cycle valid strobe. It generalises the per-slot pan/enable output latch to any channel count, input width and output width, and adds frame summation, saturation and error reporting.

## Interface
Parameters:
- NUM_CH, 6, channels per frame (2..16)
- IN_W, 9, channel sample width, offset binary, midpoint (1<<(IN_W-1)) = zero
- OUT_W, 16, output PCM width, two's complement
- GAIN_SHIFT, 5, left shift applied to the frame sum before saturation
- LPF_SHIFT, 3, filter coefficient shift; used only with the macro

Ports (clock and reset first):
- MCLK  in  1  clock; every register is on posedge
- reset  in  1  asynchronous, active-high; clears all state
- slot_en  in  1  qualifier; the slot fields below are sampled only when this is high
- slot_ch  in  $clog2(NUM_CH)  channel index of the slot
- slot_data  in  IN_W  channel sample, offset binary
- slot_pan  in  2  bit0 = right enable, bit1 = left enable
- slot_active  in  1  output-enable; when 0 the slot contributes zero
- out_l, out_r  out  OUT_W  signed frame sample
- out_valid  out  1  one-cycle pulse when out_l/out_r update
- clip  out  2  per-frame saturation flags {L,R}, updated with out_valid
- dup_err  out  1  sticky; set on duplicate or out-of-range channel index

## Operation
- Signed conversion: s = slot_data with its MSB inverted, read as two's complement. Range is -(1<<(IN_W-1)) .. (1<<(IN_W-1))-1.
- Contribution per side: s when slot_active is 1 and the pan bit for that side is 1; otherwise 0.
- Accumulator width: A = IN_W + $clog2(NUM_CH) + 1. Accumulators cannot overflow within a frame.
- seen[NUM_CH-1:0] tracks the channels already accumulated in the current frame.
- Accepted slot (slot_en=1, slot_ch < NUM_CH, seen[slot_ch]=0):
  - add the contribution to each accumulator;
  - set seen[slot_ch].
- Duplicate slot (seen[slot_ch]=1) or slot_ch >= NUM_CH:
  - contribution is discarded;
  - dup_err is set and stays set until reset;
  - if slot_ch = NUM_CH-1, the frame still closes using the existing sum.
- Frame close, triggered by any slot_en with slot_ch = NUM_CH-1:
  - final = acc + this slot's contribution (0 if the slot was discarded);
  - the output is computed as below;
  - acc_l, acc_r and seen reload to 0 on the same edge.
- Channels missing from a frame contribute 0. No timeout.
- Output computation: y = final <<< GAIN_SHIFT, computed at full width and then saturated to OUT_W:
  - above 2^(OUT_W-1)-1 → 0x7FFF..;
  - below -2^(OUT_W-1) → 0x800..0;
  - the matching clip bit is 1 when saturation occurred, else 0.
- When slot_en = 0 the block holds all state except out_valid.

## Timing
- Reset values: out_l = 0, out_r = 0, out_valid = 0, clip = 0, dup_err = 0, accumulators = 0, seen = 0, LPF state = 0.
- One slot can be accepted every cycle; there is no back-pressure.
- Latency: the edge that samples the closing slot also registers out_l, out_r and clip, and raises out_valid for exactly one cycle. Outputs are visible in the cycle after that slot is presented.
- Back-to-back frames: the first slot of the next frame may arrive on the cycle immediately after the close. It accumulates into the cleared accumulators.
- Reset asserted mid-frame discards the partial frame. The first frame after reset starts empty.
- out_l, out_r and clip hold their values between pulses.

## Configuration
- YM_STEREO_ACC_LPF_EN defined:
  - adds a per-side one-pole IIR after saturation: f += (y - f) >>> LPF_SHIFT, with f held at OUT_W+LPF_SHIFT bits;
  - out_l/out_r = f[MSB:LPF_SHIFT];
  - the filter updates once per frame;
  - out_valid, out_l/out_r and clip are delayed one extra cycle, giving 2-cycle latency;
  - clip still reflects the pre-filter saturation.
- Undefined: no filter and 1-cycle latency as described above.

## Test plan
Defaults apply (NUM_CH=6, IN_W=9, OUT_W=16, GAIN_SHIFT=5, macro undefined).
1. Channels 0..5, all slot_data = 0x100, pan = 3, active → out_l = out_r = 0x0000, clip = 0, one out_valid pulse one cycle after ch5.
2. ch0 = 0x180, pan = 1, active; ch1..5 = 0x100 → out_r = 0x1000, out_l = 0x0000. Repeat with ch0 slot_active = 0 → out_r = 0x0000.
3. All six channels = 0x1FF, pan = 3 → out_l = out_r = 0x7FFF, clip = 2'b11. All six = 0x000 → out_l = out_r = 0x8000, clip = 2'b11.
4. ch2 = 0x140 sent twice, then ch5 = 0x100, pan = 3 → out_l = out_r = 0x0800 (counted once), dup_err = 1 and stays 1 across the following frames.
5. reset pulsed after ch0..3 = 0x1FF; then a frame with only ch5 = 0x110 → out_l = out_r = 0x0200. Back-to-back frames with no idle cycle give one out_valid per frame.
6. YM_STEREO_ACC_LPF_EN defined, LPF_SHIFT = 3, a constant frame value of 0x0800 → successive outputs 0x0100, 0x01E0, 0x02A4..., converging to 0x0800, each pulse 2 cycles after ch5.
